// File: rtl/pcpi_initiator_if.sv
// rtl/pcpi_initiator_if.sv - host request/response and PCPI bus bundle for pcpi_initiator
// slave is the initiator's view; master is the host/coprocessor environment.
interface pcpi_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_insn;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rd;
  logic        resp_wr;
  logic        resp_trap;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_busy;
  logic        pcpi_ready;

  modport slave (
    input  req_valid, req_insn, req_rs1, req_rs2, resp_ready,
           pcpi_wr, pcpi_rd, pcpi_busy, pcpi_ready,
    output req_ready, resp_valid, resp_rd, resp_wr, resp_trap,
           pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2
  );

  modport master (
    output req_valid, req_insn, req_rs1, req_rs2, resp_ready,
           pcpi_wr, pcpi_rd, pcpi_busy, pcpi_ready,
    input  req_ready, resp_valid, resp_rd, resp_wr, resp_trap,
           pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2
  );
endinterface

// File: rtl/pcpi_initiator.sv
// rtl/pcpi_initiator.sv - issues one host instruction to a PCPI coprocessor and returns its result
// Optional unclaimed-instruction trap enabled by defining PCPI_INITIATOR_TIMEOUT_EN.
module pcpi_initiator #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  pcpi_initiator_if.slave      bus
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("pcpi_initiator: TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t      state_q;
  logic        req_ready_q;
  logic        pcpi_valid_q;
  logic        resp_valid_q;
  logic [31:0] insn_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic [31:0] rd_q;
  logic        wr_q;
  logic        trap_q;
  logic        timeout_hit;

`ifdef PCPI_INITIATOR_TIMEOUT_EN
  localparam logic [7:0] LastCount = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q;
  logic       claimed_q;

  // pcpi_ready takes priority over this in the FSM, so it is not gated here.
  assign timeout_hit = (cnt_q == LastCount) && !bus.pcpi_busy && !claimed_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q     <= '0;
      claimed_q <= 1'b0;
    end else if (state_q == IDLE) begin
      cnt_q     <= '0;
      claimed_q <= 1'b0;
    end else if (state_q == ISSUE) begin
      if (bus.pcpi_busy) begin
        claimed_q <= 1'b1;
      end else if (!bus.pcpi_ready && !claimed_q) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end
`else
  logic unused_busy;
  assign unused_busy = bus.pcpi_busy;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      pcpi_valid_q <= 1'b0;
      resp_valid_q <= 1'b0;
      insn_q       <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      wr_q         <= 1'b0;
      trap_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            insn_q       <= bus.req_insn;
            rs1_q        <= bus.req_rs1;
            rs2_q        <= bus.req_rs2;
            req_ready_q  <= 1'b0;
            pcpi_valid_q <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.pcpi_ready) begin
            rd_q         <= bus.pcpi_rd;
            wr_q         <= bus.pcpi_wr;
            trap_q       <= 1'b0;
            pcpi_valid_q <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else if (timeout_hit) begin
            rd_q         <= '0;
            wr_q         <= 1'b0;
            trap_q       <= 1'b1;
            pcpi_valid_q <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          // Result fields return to zero with resp_valid so idle outputs read as 0.
          if (bus.resp_ready) begin
            rd_q         <= '0;
            wr_q         <= 1'b0;
            trap_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          req_ready_q  <= 1'b1;
          pcpi_valid_q <= 1'b0;
          resp_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.pcpi_valid = pcpi_valid_q;
  assign bus.pcpi_insn  = insn_q;
  assign bus.pcpi_rs1   = rs1_q;
  assign bus.pcpi_rs2   = rs2_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rd    = rd_q;
  assign bus.resp_wr    = wr_q;
  assign bus.resp_trap  = trap_q;

endmodule

// File: tb/tb_pcpi_initiator.sv
// tb/tb_pcpi_initiator.sv - directed stimulus with a queued scoreboard for pcpi_initiator
module tb_pcpi_initiator;

  typedef struct {
    logic [31:0] rd;
    logic        wr;
    logic        trap;
  } exp_t;

  logic clk;
  logic resetn;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;
  exp_t exp_q[$];

  pcpi_initiator_if bus();

  pcpi_initiator #(.TIMEOUT_CYCLES(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] rd, input logic wr, input logic trap);
    exp_t e;
    e.rd = rd;
    e.wr = wr;
    e.trap = trap;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
    chk("req_ready_before_issue", 32'(bus.req_ready), 32'd1);
    bus.req_insn  = insn;
    bus.req_rs1   = rs1;
    bus.req_rs2   = rs2;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("pcpi_valid_cycle1", 32'(bus.pcpi_valid), 32'd1);
    chk("pcpi_insn", bus.pcpi_insn, insn);
    chk("pcpi_rs1", bus.pcpi_rs1, rs1);
    chk("pcpi_rs2", bus.pcpi_rs2, rs2);
  endtask

  task automatic pulse_ready(input logic [31:0] rd, input logic wr);
    bus.pcpi_ready = 1'b1;
    bus.pcpi_rd    = rd;
    bus.pcpi_wr    = wr;
    tick();
    bus.pcpi_ready = 1'b0;
    bus.pcpi_busy  = 1'b0;
    bus.pcpi_rd    = 32'hFFFF_FFFF;
    bus.pcpi_wr    = 1'b1;
    chk("resp_valid_after_ready", 32'(bus.resp_valid), 32'd1);
    chk("pcpi_valid_after_ready", 32'(bus.pcpi_valid), 32'd0);
  endtask

  // Scoreboard monitor: pops an expectation on every response handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.resp_valid && bus.resp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL resp_unexpected: got rd=0x%08h wr=%0b trap=%0b expected no response",
                   bus.resp_rd, bus.resp_wr, bus.resp_trap);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("resp_rd", bus.resp_rd, e.rd);
          chk("resp_wr", 32'(bus.resp_wr), 32'(e.wr));
          chk("resp_trap", 32'(bus.resp_trap), 32'(e.trap));
        end
      end else if (!bus.resp_valid) begin
        chk("resp_rd_idle_zero", bus.resp_rd, 32'd0);
        chk("resp_flags_idle_zero", 32'({bus.resp_wr, bus.resp_trap}), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn         = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_insn   = '0;
    bus.req_rs1    = '0;
    bus.req_rs2    = '0;
    bus.resp_ready = 1'b1;
    bus.pcpi_wr    = 1'b0;
    bus.pcpi_rd    = '0;
    bus.pcpi_busy  = 1'b0;
    bus.pcpi_ready = 1'b0;
    repeat (3) tick();
    chk("rst_pcpi_valid", 32'(bus.pcpi_valid), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_pcpi_insn", bus.pcpi_insn, 32'd0);
    chk("rst_pcpi_rs1", bus.pcpi_rs1, 32'd0);
    chk("rst_resp_rd", bus.resp_rd, 32'd0);
    resetn = 1'b1;
    mon_en = 1'b1;
    tick();
    chk("req_ready_after_reset", 32'(bus.req_ready), 32'd1);

    // MUL answered in cycle 1: response in cycle 2.
    push(32'd42, 1'b1, 1'b0);
    issue(32'h02B5_0533, 32'd7, 32'd6);
    chk("req_ready_in_issue", 32'(bus.req_ready), 32'd0);
    pulse_ready(32'd42, 1'b1);
    tick();
    chk("req_ready_after_resp", 32'(bus.req_ready), 32'd1);

    // DIVU claimed via busy for 40 cycles, well beyond the timeout.
    push(32'd14, 1'b1, 1'b0);
    issue(32'h02B5_5533, 32'd100, 32'd7);
    bus.pcpi_busy = 1'b1;
    repeat (40) tick();
    chk("busy_pcpi_valid_held", 32'(bus.pcpi_valid), 32'd1);
    chk("busy_no_resp", 32'(bus.resp_valid), 32'd0);
    pulse_ready(32'd14, 1'b1);
    tick();

    // Unclaimed instruction with no busy or ready.
`ifdef PCPI_INITIATOR_TIMEOUT_EN
    push(32'd0, 1'b0, 1'b1);
    issue(32'h0000_000B, 32'd1, 32'd2);
    repeat (15) tick();
    chk("unclaimed_cycle16_pcpi_valid", 32'(bus.pcpi_valid), 32'd1);
    chk("unclaimed_cycle16_no_resp", 32'(bus.resp_valid), 32'd0);
    tick();
    chk("trap_pcpi_valid_low", 32'(bus.pcpi_valid), 32'd0);
    chk("trap_resp_valid", 32'(bus.resp_valid), 32'd1);
    tick();
`else
    push(32'd5, 1'b0, 1'b0);
    issue(32'h0000_000B, 32'd1, 32'd2);
    repeat (35) tick();
    chk("no_timeout_pcpi_valid", 32'(bus.pcpi_valid), 32'd1);
    chk("no_timeout_no_resp", 32'(bus.resp_valid), 32'd0);
    pulse_ready(32'd5, 1'b0);
    tick();
`endif

    // pcpi_ready on the 16th unclaimed cycle beats the timeout.
    push(32'h0000_1234, 1'b1, 1'b0);
    issue(32'h0000_000B, 32'd3, 32'd4);
    repeat (15) tick();
    pulse_ready(32'h0000_1234, 1'b1);
    tick();

    // Host back-pressure while a new request waits.
    bus.resp_ready = 1'b0;
    push(32'h0000_A5A5, 1'b1, 1'b0);
    issue(32'h02B5_0533, 32'd11, 32'd12);
    pulse_ready(32'h0000_A5A5, 1'b1);
    bus.req_insn  = 32'h02C5_8633;
    bus.req_rs1   = 32'd3;
    bus.req_rs2   = 32'd4;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("stall_resp_rd", bus.resp_rd, 32'h0000_A5A5);
      chk("stall_resp_wr", 32'(bus.resp_wr), 32'd1);
      chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
      chk("stall_pcpi_insn", bus.pcpi_insn, 32'h02B5_0533);
    end
    bus.resp_ready = 1'b1;
    tick();
    chk("turnaround_req_ready", 32'(bus.req_ready), 32'd1);
    chk("turnaround_pcpi_valid", 32'(bus.pcpi_valid), 32'd0);
    push(32'd12, 1'b1, 1'b0);
    tick();
    bus.req_valid = 1'b0;
    chk("second_req_pcpi_valid", 32'(bus.pcpi_valid), 32'd1);
    chk("second_req_pcpi_insn", bus.pcpi_insn, 32'h02C5_8633);
    chk("second_req_pcpi_rs1", bus.pcpi_rs1, 32'd3);
    pulse_ready(32'd12, 1'b1);
    tick();

    // Reset mid-ISSUE aborts; a stray ready afterwards is ignored.
    issue(32'h02B5_0533, 32'd9, 32'd9);
    tick();
    resetn = 1'b0;
    tick();
    chk("abort_pcpi_valid", 32'(bus.pcpi_valid), 32'd0);
    chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("abort_pcpi_insn", bus.pcpi_insn, 32'd0);
    resetn         = 1'b1;
    bus.pcpi_ready = 1'b1;
    bus.pcpi_rd    = 32'h0000_DEAD;
    bus.pcpi_wr    = 1'b1;
    tick();
    bus.pcpi_ready = 1'b0;
    chk("stray_ready_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("stray_ready_pcpi_valid", 32'(bus.pcpi_valid), 32'd0);
    tick();
    chk("stray_ready_still_idle", 32'(bus.resp_valid), 32'd0);
    push(32'd99, 1'b1, 1'b0);
    issue(32'h02B5_0533, 32'd9, 32'd11);
    pulse_ready(32'd99, 1'b1);
    repeat (2) tick();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
